// File: rtl/dt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dt_pkg
// Description : Shared types and helpers for the programmable decision-tree
//               classifier (walk FSM states, node sizing, default geometry).
// Revision    : 1.0 - initial release
// ============================================================================
package dt_pkg;

  // Default engine geometry, used as parameter defaults by the modules
  localparam int C_N_FEAT_DEF    = 8;
  localparam int C_CLS_W_DEF     = 2;
  localparam int C_N_NODES_DEF   = 32;
  localparam int C_DEPTH_MAX_DEF = 8;

  // Walk controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_e;

  // Packed node width: {leaf, feat_idx, child0, child1, cls}
  function automatic int node_width(input int n_feat, input int n_nodes, input int cls_w);
    return 1 + $clog2(n_feat) + 2 * $clog2(n_nodes) + cls_w;
  endfunction

endpackage : dt_pkg
`default_nettype wire

// File: rtl/dt_node_table.sv
`default_nettype none
// ============================================================================
// Module      : dt_node_table
// Description : N_NODES-entry node register file. Async reset loads every
//               entry with a class-0 leaf. One synchronous write port, one
//               combinational read port. Out-of-range reads return the
//               reset leaf; out-of-range writes are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module dt_node_table
  import dt_pkg::*;
#(
  parameter int N_NODES = C_N_NODES_DEF,
  parameter int AW      = $clog2(C_N_NODES_DEF),
  parameter int NW      = node_width(C_N_FEAT_DEF, C_N_NODES_DEF, C_CLS_W_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [NW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [NW-1:0] rdata
);

  // Reset content: leaf bit (MSB) set, every other field zero
  localparam logic [NW-1:0] C_RST_NODE = {1'b1, {(NW-1){1'b0}}};

  logic [NW-1:0] r_mem [N_NODES];
  logic          w_wr_ok;
  logic          w_rd_ok;

  // Address range qualification only matters when N_NODES is not a power of 2
  generate
    if (N_NODES == (1 << AW)) begin : g_full_range
      assign w_wr_ok = 1'b1;
      assign w_rd_ok = 1'b1;
    end else begin : g_partial_range
      assign w_wr_ok = ({1'b0, waddr} < (AW+1)'(N_NODES));
      assign w_rd_ok = ({1'b0, raddr} < (AW+1)'(N_NODES));
    end
  endgenerate

  // Table storage: async reset to leaf/class 0, synchronous write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NODES; i++) begin
        r_mem[i] <= C_RST_NODE;
      end
    end else if (we && w_wr_ok) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Combinational read; nonexistent children behave as a class-0 leaf
  assign rdata = w_rd_ok ? r_mem[raddr] : C_RST_NODE;

endmodule : dt_node_table
`default_nettype wire

// File: rtl/dt_engine.sv
`default_nettype none
// ============================================================================
// Module      : dt_engine
// Description : Programmable decision-tree classifier. Accepts a feature
//               vector over valid/ready, walks one tree level per clock
//               through a run-time-writable node table and returns the
//               class (or a depth-abort flag) over a second valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module dt_engine
  import dt_pkg::*;
#(
  parameter  int N_FEAT    = C_N_FEAT_DEF,
  parameter  int CLS_W     = C_CLS_W_DEF,
  parameter  int N_NODES   = C_N_NODES_DEF,
  parameter  int DEPTH_MAX = C_DEPTH_MAX_DEF,
  localparam int FW        = $clog2(N_FEAT),
  localparam int AW        = $clog2(N_NODES),
  localparam int NW        = node_width(N_FEAT, N_NODES, CLS_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_FEAT-1:0] in_feat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CLS_W-1:0]  out_class,
  output logic              out_err,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [NW-1:0]     cfg_node,
  output logic              cfg_err
);

  localparam int SW = $clog2(DEPTH_MAX + 1);
  localparam logic [SW-1:0] C_LAST_STEP = SW'(DEPTH_MAX - 1);

  typedef struct packed {
    logic             leaf;
    logic [FW-1:0]    feat_idx;
    logic [AW-1:0]    child0;
    logic [AW-1:0]    child1;
    logic [CLS_W-1:0] cls;
  } node_t;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [N_FEAT-1:0] r_feat;
  logic [AW-1:0]    r_cur;
  logic [SW-1:0]    r_steps;
  logic [CLS_W-1:0] r_class;
  logic             r_err;
  logic             r_cfg_err;

  logic [NW-1:0]    w_node_raw;
  node_t            w_node;
  logic             w_fbit;
  logic             w_accept;
  logic             w_advance;
  logic             w_finish;
  logic             w_abort;
  logic             w_tbl_we;

  // Table writes are only allowed while no walk is in flight
  assign w_tbl_we = cfg_we && (r_state == IDLE);

  dt_node_table #(
    .N_NODES (N_NODES),
    .AW      (AW),
    .NW      (NW)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (w_tbl_we),
    .waddr (cfg_addr),
    .wdata (cfg_node),
    .raddr (r_cur),
    .rdata (w_node_raw)
  );

  assign w_node = node_t'(w_node_raw);

  // Feature indices beyond the vector read as 0 (only possible for non-pow2 N_FEAT)
  generate
    if (N_FEAT == (1 << FW)) begin : g_feat_full
      assign w_fbit = r_feat[w_node.feat_idx];
    end else begin : g_feat_partial
      assign w_fbit = ({1'b0, w_node.feat_idx} < (FW+1)'(N_FEAT)) ? r_feat[w_node.feat_idx] : 1'b0;
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_advance   = 1'b0;
    w_finish    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = WALK;
        end
      end
      WALK: begin
        if (w_node.leaf) begin
          w_finish    = 1'b1;
          w_state_nxt = DONE;
        end else if (r_steps == C_LAST_STEP) begin
          w_abort     = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_advance   = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Input latch, walk pointer, step counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_feat  <= '0;
      r_cur   <= '0;
      r_steps <= '0;
      r_class <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_feat  <= in_feat;
        r_cur   <= '0;
        r_steps <= '0;
      end
      if (w_advance) begin
        r_cur   <= w_fbit ? w_node.child1 : w_node.child0;
        r_steps <= r_steps + SW'(1);
      end
      if (w_finish) begin
        r_class <= w_node.cls;
        r_err   <= 1'b0;
      end
      if (w_abort) begin
        r_class <= '0;
        r_err   <= 1'b1;
      end
    end
  end

  // Rejected-write pulse: any write strobe outside IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we && (r_state != IDLE);
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_class = r_class;
  assign out_err   = r_err;
  assign cfg_err   = r_cfg_err;

endmodule : dt_engine
`default_nettype wire

// File: tb/tb_dt_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_dt_engine
// Description : Scoreboard bench for dt_engine. Stimulus pushes expected
//               class/err/arrival-cycle; a monitor pops on each new result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dt_engine;

  localparam int N_FEAT    = 8;
  localparam int CLS_W     = 2;
  localparam int N_NODES   = 32;
  localparam int DEPTH_MAX = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_feat = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_class;
  logic        out_err;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [15:0] cfg_node = '0;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [1:0] cls;
    logic       err;
    int         cyc;
  } exp_t;
  exp_t q[$];

  dt_engine #(
    .N_FEAT    (N_FEAT),
    .CLS_W     (CLS_W),
    .N_NODES   (N_NODES),
    .DEPTH_MAX (DEPTH_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_feat   (in_feat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_err   (out_err),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_node  (cfg_node),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mk(input logic leaf, input logic [2:0] f,
                                     input logic [4:0] c0, input logic [4:0] c1,
                                     input logic [1:0] cls);
    return {leaf, f, c0, c1, cls};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one pop per new result presentation
  initial begin
    bit   seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got class %0d err %0d, expected no result", out_class, out_err);
        end else begin
          e = q.pop_front();
          check("out_class", out_class, e.cls);
          check("out_err", out_err, e.err);
          check("result_cycle", cyc, e.cyc);
        end
      end else if (!out_valid) begin
        seen = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] f, input logic [1:0] c, input logic e,
                      input int lat, input bit expect_it);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_feat  = f;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready 0, expected 1 within 50 cycles");
      in_valid = 1'b0;
      return;
    end
    if (expect_it) q.push_back('{c, e, cyc + lat});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(in_ready && q.size() == 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(in_ready && q.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got pending %0d in_ready %0d, expected 0 and 1", q.size(), in_ready);
    end
  endtask

  task automatic cfg(input logic [4:0] a, input logic [15:0] n);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_node = n;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    // Reset values while reset is held
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_class", out_class, 0);
    check("rst_out_err", out_err, 0);
    check("rst_cfg_err", cfg_err, 0);
    @(negedge clk);
    rst = 1'b0;

    // Unprogrammed table: root is a class-0 leaf
    send(8'hA5, 2'd0, 1'b0, 2, 1'b1);
    wait_idle();

    // Three-level tree
    cfg(5'd0, mk(1'b0, 3'd6, 5'd1, 5'd2, 2'd0));
    check("cfg_err_idle", cfg_err, 0);
    cfg(5'd1, mk(1'b0, 3'd7, 5'd3, 5'd4, 2'd0));
    cfg(5'd2, mk(1'b1, 3'd0, 5'd0, 5'd0, 2'd2));
    cfg(5'd3, mk(1'b1, 3'd0, 5'd0, 5'd0, 2'd1));
    cfg(5'd4, mk(1'b1, 3'd0, 5'd0, 5'd0, 2'd0));
    send(8'h40, 2'd2, 1'b0, 3, 1'b1); wait_idle();
    send(8'h00, 2'd1, 1'b0, 4, 1'b1); wait_idle();
    send(8'h80, 2'd0, 1'b0, 4, 1'b1); wait_idle();
    send(8'hC0, 2'd2, 1'b0, 3, 1'b1); wait_idle();

    // Backpressure: result held for 10 cycles
    out_ready = 1'b0;
    send(8'h00, 2'd1, 1'b0, 4, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", out_valid, 1);
    repeat (10) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_class", out_class, 1);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);

    // Write during a walk is rejected and leaves the table intact
    send(8'h00, 2'd1, 1'b0, 4, 1'b1);
    cfg(5'd3, mk(1'b1, 3'd0, 5'd0, 5'd0, 2'd3));
    check("cfg_err_walk_pulse", cfg_err, 1);
    @(posedge clk);
    #1 check("cfg_err_walk_end", cfg_err, 0);
    wait_idle();
    send(8'h00, 2'd1, 1'b0, 4, 1'b1); wait_idle();

    // Same write in IDLE takes effect
    cfg(5'd3, mk(1'b1, 3'd0, 5'd0, 5'd0, 2'd3));
    check("cfg_err_idle2", cfg_err, 0);
    send(8'h00, 2'd3, 1'b0, 4, 1'b1); wait_idle();

    // Self-loop at the root: depth abort
    cfg(5'd0, mk(1'b0, 3'd0, 5'd0, 5'd0, 2'd3));
    send(8'h00, 2'd0, 1'b1, DEPTH_MAX + 1, 1'b1); wait_idle();
    send(8'hFF, 2'd0, 1'b1, DEPTH_MAX + 1, 1'b1); wait_idle();

    // Reset in the middle of a walk
    send(8'h00, 2'd0, 1'b0, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_err", out_err, 0);
    @(negedge clk);
    rst = 1'b0;
    send(8'hA5, 2'd0, 1'b0, 2, 1'b1); wait_idle();
    send(8'h40, 2'd0, 1'b0, 2, 1'b1); wait_idle();

    // Write in the handshake cycle is seen by that walk
    @(negedge clk);
    in_valid = 1'b1;
    in_feat  = 8'h00;
    cfg_we   = 1'b1;
    cfg_addr = 5'd0;
    cfg_node = mk(1'b1, 3'd0, 5'd0, 5'd0, 2'd2);
    check("same_cycle_in_ready", in_ready, 1);
    q.push_back('{2'd2, 1'b0, cyc + 2});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    check("same_cycle_cfg_err", cfg_err, 0);
    wait_idle();

    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dt_engine
`default_nettype wire

// File: doc/dt_engine.md
Name: dt_engine

Overview:
- Programmable, parametrised decision-tree classifier; successor to our fixed, hard-wired combinational tree classifiers.
- The tree is held in a run-time-writable node table instead of being baked into logic.
- A feature vector is accepted over a valid/ready handshake. The engine walks one tree level per clock and returns the class over a second valid/ready handshake.
- Sits between the feature-capture stage and the class consumer; one engine is reused for any trained tree that fits N_NODES/DEPTH_MAX.

Parameters:
- N_FEAT, 8, number of 1-bit features in the input vector.
- CLS_W, 2, class label width.
- N_NODES, 32, node-table entries; node 0 is always the root.
- DEPTH_MAX, 8, maximum nodes visited per classification before abort.
- Derived (localparam): FW = $clog2(N_FEAT), AW = $clog2(N_NODES).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  feature vector valid.
- in_ready  out  1  engine idle, can accept.
- in_feat  in  N_FEAT  feature vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_class  out  CLS_W  predicted class.
- out_err  out  1  walk aborted (depth exceeded).
- cfg_we  in  1  node-table write strobe.
- cfg_addr  in  AW  node index.
- cfg_node  in  1+FW+2*AW+CLS_W  packed node: {leaf, feat_idx, child0, child1, cls}.
- cfg_err  out  1  one-cycle pulse: write rejected.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; in_ready=1; out_valid=0; out_class=0; out_err=0; cfg_err=0.
  - Every table entry is reset to leaf=1, cls=0, all other fields 0. An unprogrammed engine therefore classifies everything as 0.
- Node semantics:
  - Leaf: result = cls.
  - Internal: next = in_feat_q[feat_idx] ? child1 : child0.
  - feat_idx >= N_FEAT reads as 0 (falls to child0).
- FSM IDLE -> WALK -> DONE:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_feat into in_feat_q, set cur=0, steps=0, go to WALK.
  - WALK: in_ready=0. Each cycle read node[cur] combinationally.
    - If leaf: register out_class=cls, out_err=0, go to DONE.
    - Else if steps==DEPTH_MAX-1: out_class=0, out_err=1, go to DONE.
    - Else: cur=next, steps+=1.
  - DONE: out_valid=1, outputs held stable. On out_ready, go to IDLE (in_ready=1 the following cycle).
- Latency: a leaf at depth d (root = 0), handshake in cycle t, gives out_valid high from cycle t+d+2. Maximum is t+DEPTH_MAX+1.
- Throughput: one vector in flight; no overlap. in_ready stays low from acceptance until the cycle after the out handshake.
- out_valid must not drop, and outputs must not change, until out_ready is seen (backpressure holds indefinitely).
- Config writes:
  - Accepted only in IDLE and take effect the next cycle.
  - A cfg_we in WALK/DONE is dropped and cfg_err pulses for 1 cycle. This protects the in-flight walk.
  - A cfg_we in the same cycle as the input handshake is accepted; the walk sees the new entry.
- Width rules: steps is $clog2(DEPTH_MAX+1) bits with no wrap (bounded by the abort rule). cur is AW bits. Child indices >= N_NODES (non-power-of-2 N_NODES) read as a reset-value leaf (cls=0).
- Reset mid-walk or mid-DONE: the result is discarded, outputs clear, and the table reverts to the reset contents.

Decomposition:
- Package dt_pkg:
  - node_t packed struct {leaf, feat_idx, child0, child1, cls} sized from the parameters (or a packing function).
  - state_e enum {IDLE, WALK, DONE}.
  - Reset-node constant.
- Sub-module dt_node_table:
  - N_NODES x node_t register file with async reset.
  - One synchronous write port (gated by the FSM's IDLE qualifier).
  - One combinational read port.
- Top dt_engine holds the FSM, input latch, step counter and output registers.

Test Plan:
- Reset, no programming, in_feat=8'hA5 -> out_valid at t+2, out_class=0, out_err=0.
- Program 3-level tree:
  - n0={0,f6,1,2}; n1={0,f7,3,4}; n2 = leaf cls=2; n3 = leaf 1; n4 = leaf 0.
  - in_feat=8'h40 -> class 2 at t+3.
  - in_feat=8'h00 -> class 1 at t+4.
  - in_feat=8'h80 -> class 0 at t+4.
- Loop n0={0,f0,0,0} with DEPTH_MAX=8 -> out_err=1, out_class=0, out_valid at t+9.
- Hold out_ready=0 for 10 cycles -> out_valid and out_class stable, in_ready=0. Then out_ready=1 -> in_ready=1 next cycle.
- cfg_we during WALK -> cfg_err one-cycle pulse; table unchanged (re-run gives identical class). cfg_we in IDLE -> no cfg_err, new leaf class observed.
- Assert rst during WALK -> out_valid=0 and in_ready=1 immediately; next classification returns 0 (table reset).
